// File: rtl/freq_ddfs_pkg.sv
// Shared types and constants for the gated frequency meter that feeds the DDFS
// range selection: FSM state encoding and the decade thresholds behind range_code.
package freq_ddfs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } meter_state_t;

    localparam int unsigned DECADES = 6;

    // Ascending, so range_code is simply how many thresholds the count reaches.
    localparam logic [63:0] DECADE_TH [0:DECADES-1] = '{
        64'd10,
        64'd100,
        64'd1000,
        64'd10000,
        64'd100000,
        64'd1000000
    };

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input plus a third flop that turns
// its synchronised rising edges into single-cycle pulses.
module sync_edge_det (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d_async,
    output logic rise_pulse
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= d_async;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign rise_pulse = sync_reg & ~prev_reg;

endmodule

// File: rtl/freq_meter_ddfs.sv
// Gated frequency meter: counts sig_in rising edges over GATE_CYCLES clocks and
// reports count, decade code and saturation. Define FREQ_METER_CONT_EN for back-to-back gates.
module freq_meter_ddfs
    import freq_ddfs_pkg::*;
#(
    parameter int GATE_CYCLES = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] freq_count,
    output logic [2:0]       range_code,
    output logic             overflow
);

    localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    meter_state_t      state_reg, state_next;
    logic [GATE_W-1:0] gate_cnt_reg, gate_cnt_next;
    logic [CNT_W-1:0]  edge_cnt_reg, edge_cnt_next;
    logic              ovf_reg, ovf_next;
    logic              latch;

    logic [CNT_W-1:0]  freq_count_reg;
    logic [2:0]        range_code_reg, range_next;
    logic              overflow_reg;
    logic              meas_valid_reg;

    logic              rise;
    logic [DECADES-1:0] reached;

    sync_edge_det u_sync (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .d_async    (sig_in),
        .rise_pulse (rise)
    );

    always_comb begin
        state_next    = state_reg;
        gate_cnt_next = gate_cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        ovf_next      = ovf_reg;
        latch         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_GATE;
                    gate_cnt_next = GATE_LOAD;
                    edge_cnt_next = '0;
                    ovf_next      = 1'b0;
                end
            end
            ST_GATE: begin
                gate_cnt_next = gate_cnt_reg - 1'b1;
                if (rise) begin
                    if (edge_cnt_reg == CNT_MAX) begin
                        ovf_next = 1'b1;
                    end else begin
                        edge_cnt_next = edge_cnt_reg + 1'b1;
                    end
                end
                // The final gate cycle's edge is already folded into edge_cnt_next.
                if (gate_cnt_reg == '0) begin
                    state_next = ST_DONE;
                    latch      = 1'b1;
                end
            end
            ST_DONE: begin
`ifdef FREQ_METER_CONT_EN
                state_next    = ST_GATE;
                gate_cnt_next = GATE_LOAD;
                edge_cnt_next = '0;
                ovf_next      = 1'b0;
`else
                state_next    = ST_IDLE;
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < DECADES; gi++) begin : g_decade
            assign reached[gi] = (64'(edge_cnt_next) >= DECADE_TH[gi]);
        end
    endgenerate

    always_comb begin
        range_next = '0;
        for (int i = 0; i < DECADES; i++) begin
            range_next = range_next + 3'(reached[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gate_cnt_reg <= gate_cnt_next;
            edge_cnt_reg <= edge_cnt_next;
            ovf_reg      <= ovf_next;
        end
    end

    // Results are captured on entry to DONE so they are valid alongside meas_valid.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            freq_count_reg <= '0;
            range_code_reg <= '0;
            overflow_reg   <= 1'b0;
            meas_valid_reg <= 1'b0;
        end else begin
            meas_valid_reg <= latch;
            if (latch) begin
                freq_count_reg <= edge_cnt_next;
                range_code_reg <= range_next;
                overflow_reg   <= ovf_next;
            end
        end
    end

    assign busy       = (state_reg != ST_IDLE);
    assign meas_valid = meas_valid_reg;
    assign freq_count = freq_count_reg;
    assign range_code = range_code_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_freq_meter_ddfs.sv
// Bench for freq_meter_ddfs (one-shot build): randomised square waves measured by
// three instances, checked against an edge-log model of the gate window.
module tb_freq_meter_ddfs;

    localparam int G  = 1000;
    localparam int GC = 24000;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    logic sig_in = 1'b0;
    logic start  = 1'b0;
    logic start_c = 1'b0;

    logic        busy_a, mv_a, ovf_a;
    logic [19:0] fc_a;
    logic [2:0]  rc_a;
    logic        busy_b, mv_b, ovf_b;
    logic [7:0]  fc_b;
    logic [2:0]  rc_b;
    logic        busy_c, mv_c, ovf_c;
    logic [19:0] fc_c;
    logic [2:0]  rc_c;

    freq_meter_ddfs #(.GATE_CYCLES(G), .CNT_W(20)) dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start),
        .busy(busy_a), .meas_valid(mv_a), .freq_count(fc_a),
        .range_code(rc_a), .overflow(ovf_a));

    freq_meter_ddfs #(.GATE_CYCLES(G), .CNT_W(8)) dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start),
        .busy(busy_b), .meas_valid(mv_b), .freq_count(fc_b),
        .range_code(rc_b), .overflow(ovf_b));

    freq_meter_ddfs #(.GATE_CYCLES(GC), .CNT_W(20)) dut_c (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start_c),
        .busy(busy_c), .meas_valid(mv_c), .freq_count(fc_c),
        .range_code(rc_c), .overflow(ovf_c));

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int mvn_a = 0;
    int mvn_b = 0;
    always @(posedge clk_in) begin
        if (mv_a === 1'b1) mvn_a <= mvn_a + 1;
        if (mv_b === 1'b1) mvn_b <= mvn_b + 1;
    end

    // Square-wave source; each 0->1 is logged with the first clock edge that samples it.
    int period = 10;
    int high   = 5;
    int ph     = 0;
    bit sig_en = 1'b0;
    int rises[$];

    always @(negedge clk_in) begin
        if (sig_en) begin
            ph = (ph + 1) % period;
            if (ph < high && sig_in == 1'b0) rises.push_back(cyc + 1);
            sig_in = (ph < high);
        end else begin
            sig_in = 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A sampled edge reaches the counter two clocks later; the gate spans edges s+1 .. s+g.
    function automatic int model_count(input int s, input int g);
        int n = 0;
        foreach (rises[i]) begin
            if (rises[i] + 2 >= s + 1 && rises[i] + 2 <= s + g) n++;
        end
        return n;
    endfunction

    function automatic int model_range(input int n);
        int r = 0;
        int v = n;
        while (v >= 10 && r < 6) begin
            v = v / 10;
            r++;
        end
        return r;
    endfunction

    task automatic measure(input int p, input int h, input bit en, input bit repulse, input string tag);
        int s, t, exp_a, exp_b, mva0, mvb0;
        bit ob;
        period = p;
        high   = h;
        sig_en = en;
        repeat ($urandom_range(3, 20)) @(negedge clk_in);
        mva0 = mvn_a;
        mvb0 = mvn_b;
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk_in);
        start = 1'b0;
        check({tag, " busy"}, 64'(busy_a), 64'd1);
        t = -1;
        for (int i = 0; i < G + 20; i++) begin
            if (mv_a === 1'b1) begin
                t = cyc;
                break;
            end
            start = (repulse && i == G / 2);
            @(negedge clk_in);
        end
        start = 1'b0;
        exp_a = model_count(s, G);
        exp_b = (exp_a > 255) ? 255 : exp_a;
        ob    = (exp_a > 255);
        check({tag, " valid_time"}, 64'(t), 64'(s + G));
        check({tag, " count_a"}, 64'(fc_a), 64'(exp_a));
        check({tag, " range_a"}, 64'(rc_a), 64'(model_range(exp_a)));
        check({tag, " ovf_a"}, 64'(ovf_a), 64'd0);
        check({tag, " valid_b"}, 64'(mv_b), 64'd1);
        check({tag, " count_b"}, 64'(fc_b), 64'(exp_b));
        check({tag, " range_b"}, 64'(rc_b), 64'(model_range(exp_b)));
        check({tag, " ovf_b"}, 64'(ovf_b), 64'(ob));
        @(negedge clk_in);
        check({tag, " valid_drop"}, 64'(mv_a), 64'd0);
        check({tag, " pulses_a"}, 64'(mvn_a - mva0), 64'd1);
        check({tag, " pulses_b"}, 64'(mvn_b - mvb0), 64'd1);
        check({tag, " idle"}, 64'(busy_a), 64'd0);
        repeat (5) @(negedge clk_in);
        check({tag, " hold"}, 64'(fc_a), 64'(exp_a));
        $display("meas %s period=%0d high=%0d en=%0d start=%0d count=%0d exp=%0d count_b=%0d exp_b=%0d",
                 tag, p, h, en, s, fc_a, exp_a, fc_b, exp_b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy_a"}, 64'(busy_a), 64'd0);
        check({tag, " mv_a"}, 64'(mv_a), 64'd0);
        check({tag, " fc_a"}, 64'(fc_a), 64'd0);
        check({tag, " rc_a"}, 64'(rc_a), 64'd0);
        check({tag, " ovf_a"}, 64'(ovf_a), 64'd0);
        check({tag, " fc_b"}, 64'(fc_b), 64'd0);
        check({tag, " ovf_b"}, 64'(ovf_b), 64'd0);
        check({tag, " busy_c"}, 64'(busy_c), 64'd0);
        check({tag, " fc_c"}, 64'(fc_c), 64'd0);
    endtask

    initial begin
        int s, t, m0, p, h, exp_c;
        bit rp;

        rst_n = 1'b0;
        repeat (4) @(negedge clk_in);
        check_reset_outputs("reset");
        $display("reset outputs checked");
        rst_n = 1'b1;

        measure(10, 5, 1'b1, 1'b0, "p10");
        measure(10, 5, 1'b0, 1'b0, "quiet");
        measure(2, 1, 1'b1, 1'b0, "p2_sat");
        measure(7, 3, 1'b1, 1'b1, "restart_ignored");
        for (int k = 0; k < 6; k++) begin
            p  = $urandom_range(2, 40);
            h  = $urandom_range(1, p - 1);
            rp = 1'($urandom_range(0, 1));
            measure(p, h, 1'b1, rp, $sformatf("rand%0d", k));
        end

        // Abort halfway through a gate.
        period = 10;
        high   = 5;
        sig_en = 1'b1;
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (500) @(negedge clk_in);
        rst_n  = 1'b0;
        sig_en = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        check_reset_outputs("abort");
        m0 = mvn_a;
        repeat (G + 10) @(negedge clk_in);
        check("abort no_valid", 64'(mvn_a - m0), 64'd0);
        check("abort still_idle", 64'(busy_a), 64'd0);
        $display("abort mid-gate checked");
        measure(10, 5, 1'b1, 1'b0, "after_abort");

        // Long gate on its own start to reach a higher decade.
        period = 2;
        high   = 1;
        sig_en = 1'b1;
        repeat (4) @(negedge clk_in);
        start_c = 1'b1;
        s = cyc + 1;
        @(negedge clk_in);
        start_c = 1'b0;
        t = -1;
        for (int i = 0; i < GC + 20; i++) begin
            if (mv_c === 1'b1) begin
                t = cyc;
                break;
            end
            @(negedge clk_in);
        end
        exp_c = model_count(s, GC);
        check("long valid_time", 64'(t), 64'(s + GC));
        check("long count", 64'(fc_c), 64'(exp_c));
        check("long range", 64'(rc_c), 64'(model_range(exp_c)));
        check("long ovf", 64'(ovf_c), 64'd0);
        $display("meas long start=%0d count=%0d exp=%0d range=%0d", s, fc_c, exp_c, rc_c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
